vrased_rst_seq: RTL and testbench

VRASED_RST_SEQ -- requirements
Module: vrased_rst_seq

---
 rtl/vrased_rst_seq.sv | 131 +++++++++++++
 tb/tb_vrased_rst_seq.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vrased_rst_seq.sv
// Reset sequencer for VRASED-style monitors: turns any monitor violation into a
// fixed-width CPU reset pulse, then waits for the CPU to fetch the reset handler.
module vrased_rst_seq #(
  parameter logic [15:0] RESET_HANDLER = 16'h0000,
  parameter int          HOLD_CYCLES   = 4,
  parameter int          WAIT_TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [5:0]  viol,
  input  logic [15:0] pc,
  input  logic        clr_cause,
  output logic        sys_rst,
  output logic [5:0]  cause,
  output logic [2:0]  first_cause,
  output logic [7:0]  viol_cnt,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD    = 2'd1,
    WAIT_PC = 2'd2
  } state_t;

  localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);
  localparam logic [7:0] WAIT_LOAD = 8'(WAIT_TIMEOUT - 1);
  localparam logic [2:0] NO_CAUSE  = 3'd7;

  state_t      state_q, state_d;
  logic        sys_rst_q, sys_rst_d;
  logic        busy_q, busy_d;
  logic [5:0]  cause_q, cause_d;
  logic [2:0]  first_q, first_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  hold_q, hold_d;
  logic [7:0]  wait_q, wait_d;
  logic        viol_any;
  logic [7:0]  cnt_inc;

  function automatic logic [2:0] lowest_idx(input logic [5:0] v);
    lowest_idx = NO_CAUSE;
    for (int i = 5; i >= 0; i--) begin
      if (v[i]) lowest_idx = 3'(i);
    end
  endfunction

  assign viol_any = |viol;
  assign cnt_inc  = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    first_d = first_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    wait_d  = wait_q;
    case (state_q)
      IDLE: begin
        if (viol_any) begin
          // A violation coinciding with an acknowledge wins: the old cause is dropped
          state_d = HOLD;
          hold_d  = HOLD_LOAD;
          cause_d = clr_cause ? viol : (cause_q | viol);
          first_d = (clr_cause || first_q == NO_CAUSE) ? lowest_idx(viol) : first_q;
          cnt_d   = cnt_inc;
        end else if (clr_cause) begin
          cause_d = 6'd0;
          first_d = NO_CAUSE;
        end
      end
      HOLD: begin
        cause_d = cause_q | viol;
        if (hold_q == 4'd0) begin
          state_d = WAIT_PC;
          wait_d  = WAIT_LOAD;
        end else begin
          hold_d = hold_q - 4'd1;
        end
      end
      WAIT_PC: begin
        if (viol_any) begin
          state_d = HOLD;
          hold_d  = HOLD_LOAD;
          cause_d = cause_q | viol;
          first_d = (first_q == NO_CAUSE) ? lowest_idx(viol) : first_q;
          cnt_d   = cnt_inc;
        end else if (pc == RESET_HANDLER) begin
          state_d = IDLE;
        end else if (wait_q == 8'd0) begin
          state_d = HOLD;
          hold_d  = HOLD_LOAD;
        end else begin
          wait_d = wait_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    sys_rst_d = (state_d == HOLD);
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      sys_rst_q <= 1'b0;
      busy_q    <= 1'b0;
      cause_q   <= 6'd0;
      first_q   <= NO_CAUSE;
      cnt_q     <= 8'd0;
      hold_q    <= 4'd0;
      wait_q    <= 8'd0;
    end else begin
      state_q   <= state_d;
      sys_rst_q <= sys_rst_d;
      busy_q    <= busy_d;
      cause_q   <= cause_d;
      first_q   <= first_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      wait_q    <= wait_d;
    end
  end

  assign sys_rst     = sys_rst_q;
  assign busy        = busy_q;
  assign cause       = cause_q;
  assign first_cause = first_q;
  assign viol_cnt    = cnt_q;

endmodule

// File: tb/tb_vrased_rst_seq.sv
// Directed bench for vrased_rst_seq with default parameters; each task covers
// one scenario and checks its own hand-computed expectations.
module tb_vrased_rst_seq;

  logic        clk;
  logic        reset_n;
  logic [5:0]  viol;
  logic [15:0] pc;
  logic        clr_cause;
  logic        sys_rst;
  logic [5:0]  cause;
  logic [2:0]  first_cause;
  logic [7:0]  viol_cnt;
  logic        busy;

  int checks = 0;
  int errors = 0;

  vrased_rst_seq dut (
    .clk(clk), .reset_n(reset_n), .viol(viol), .pc(pc), .clr_cause(clr_cause),
    .sys_rst(sys_rst), .cause(cause), .first_cause(first_cause),
    .viol_cnt(viol_cnt), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500us;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  // Inputs change 1 time unit after the rising edge, so outputs are sampled there too
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts consecutive high sys_rst cycles starting with the current one
  task automatic measure_pulse(output int n);
    n = 0;
    for (int k = 0; k < 40 && sys_rst; k++) begin
      n++;
      tick();
    end
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 40 && busy; k++) tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; viol = '0; pc = 16'h1234; clr_cause = 1'b0;
    #23;
    checks++; if (sys_rst !== 1'b0) begin errors++; $display("[TB] FAIL rst_sys_rst got %b want 0", sys_rst); end
    checks++; if (cause !== 6'h00) begin errors++; $display("[TB] FAIL rst_cause got %h want 00", cause); end
    checks++; if (first_cause !== 3'd7) begin errors++; $display("[TB] FAIL rst_first got %0d want 7", first_cause); end
    checks++; if (viol_cnt !== 8'h00) begin errors++; $display("[TB] FAIL rst_cnt got %h want 00", viol_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy got %b want 0", busy); end
    tick();
    reset_n = 1'b1;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_idle_after got %b want 0", busy); end
  endtask

  task automatic test_basic();
    int n;
    pc = 16'h1234; viol = 6'b000010;
    tick();
    viol = '0;
    checks++; if (sys_rst !== 1'b1) begin errors++; $display("[TB] FAIL basic_latency got %b want 1", sys_rst); end
    measure_pulse(n);
    checks++; if (n !== 4) begin errors++; $display("[TB] FAIL basic_pulse got %0d want 4", n); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL basic_wait_busy got %b want 1", busy); end
    pc = 16'h0000;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL basic_idle got %b want 0", busy); end
    checks++; if (cause !== 6'h02) begin errors++; $display("[TB] FAIL basic_cause got %h want 02", cause); end
    checks++; if (first_cause !== 3'd1) begin errors++; $display("[TB] FAIL basic_first got %0d want 1", first_cause); end
    checks++; if (viol_cnt !== 8'd1) begin errors++; $display("[TB] FAIL basic_cnt got %0d want 1", viol_cnt); end
  endtask

  task automatic test_hold_or();
    int n;
    clr_cause = 1'b1;
    tick();
    clr_cause = 1'b0;
    checks++; if (cause !== 6'h00) begin errors++; $display("[TB] FAIL clr_cause got %h want 00", cause); end
    checks++; if (first_cause !== 3'd7) begin errors++; $display("[TB] FAIL clr_first got %0d want 7", first_cause); end
    pc = 16'h1234; viol = 6'b100100;
    tick();
    viol = '0;
    checks++; if (first_cause !== 3'd2) begin errors++; $display("[TB] FAIL hold_first got %0d want 2", first_cause); end
    checks++; if (cause !== 6'h24) begin errors++; $display("[TB] FAIL hold_cause0 got %h want 24", cause); end
    n = 1;
    for (int k = 0; k < 20 && sys_rst; k++) begin
      viol = (k == 1) ? 6'b000001 : 6'b000000;
      tick();
      if (sys_rst) n++;
    end
    viol = '0;
    checks++; if (n !== 4) begin errors++; $display("[TB] FAIL hold_pulse got %0d want 4", n); end
    checks++; if (cause !== 6'h25) begin errors++; $display("[TB] FAIL hold_cause1 got %h want 25", cause); end
    checks++; if (viol_cnt !== 8'd2) begin errors++; $display("[TB] FAIL hold_cnt got %0d want 2", viol_cnt); end
    checks++; if (first_cause !== 3'd2) begin errors++; $display("[TB] FAIL hold_first_kept got %0d want 2", first_cause); end
    pc = 16'h0000;
    tick();
  endtask

  task automatic test_timeout();
    int n;
    int w;
    pc = 16'h1234; viol = 6'b001000;
    tick();
    viol = '0;
    measure_pulse(n);
    checks++; if (n !== 4) begin errors++; $display("[TB] FAIL tmo_pulse0 got %0d want 4", n); end
    w = 1;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (sys_rst) break;
      w++;
    end
    checks++; if (w !== 16) begin errors++; $display("[TB] FAIL tmo_wait_len got %0d want 16", w); end
    checks++; if (viol_cnt !== 8'd3) begin errors++; $display("[TB] FAIL tmo_cnt got %0d want 3", viol_cnt); end
    measure_pulse(n);
    checks++; if (n !== 4) begin errors++; $display("[TB] FAIL tmo_pulse1 got %0d want 4", n); end
    pc = 16'h0000;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL tmo_idle got %b want 0", busy); end
    checks++; if (cause !== 6'h2D) begin errors++; $display("[TB] FAIL tmo_cause got %h want 2d", cause); end
    checks++; if (viol_cnt !== 8'd3) begin errors++; $display("[TB] FAIL tmo_cnt_end got %0d want 3", viol_cnt); end
  endtask

  task automatic test_wait_priority();
    int n;
    pc = 16'h1234; viol = 6'b000001;
    tick();
    viol = '0;
    measure_pulse(n);
    pc = 16'h0000; viol = 6'b010000;
    tick();
    viol = '0;
    checks++; if (sys_rst !== 1'b1) begin errors++; $display("[TB] FAIL prio_rehold got %b want 1", sys_rst); end
    checks++; if (viol_cnt !== 8'd5) begin errors++; $display("[TB] FAIL prio_cnt got %0d want 5", viol_cnt); end
    checks++; if (cause !== 6'h3D) begin errors++; $display("[TB] FAIL prio_cause got %h want 3d", cause); end
    measure_pulse(n);
    checks++; if (n !== 4) begin errors++; $display("[TB] FAIL prio_pulse got %0d want 4", n); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL prio_idle got %b want 0", busy); end
  endtask

  task automatic test_clr_in_hold();
    int n;
    pc = 16'h1234; viol = 6'b000100;
    tick();
    viol = '0; clr_cause = 1'b1;
    tick();
    clr_cause = 1'b0;
    checks++; if (cause !== 6'h3D) begin errors++; $display("[TB] FAIL clrhold_cause got %h want 3d", cause); end
    checks++; if (first_cause !== 3'd2) begin errors++; $display("[TB] FAIL clrhold_first got %0d want 2", first_cause); end
    checks++; if (viol_cnt !== 8'd6) begin errors++; $display("[TB] FAIL clrhold_cnt got %0d want 6", viol_cnt); end
    measure_pulse(n);
    pc = 16'h0000;
    tick();
  endtask

  task automatic test_saturate();
    pc = 16'h0000;
    for (int e = 0; e < 260; e++) begin
      viol = 6'b000001;
      tick();
      viol = '0;
      wait_idle();
      if (e == 247) begin
        checks++; if (viol_cnt !== 8'hFE) begin errors++; $display("[TB] FAIL sat_fe got %h want fe", viol_cnt); end
      end
      if (e == 248) begin
        checks++; if (viol_cnt !== 8'hFF) begin errors++; $display("[TB] FAIL sat_ff got %h want ff", viol_cnt); end
      end
    end
    checks++; if (viol_cnt !== 8'hFF) begin errors++; $display("[TB] FAIL sat_hold got %h want ff", viol_cnt); end
    clr_cause = 1'b1;
    tick();
    clr_cause = 1'b0;
    checks++; if (cause !== 6'h00) begin errors++; $display("[TB] FAIL sat_clr_cause got %h want 00", cause); end
    checks++; if (first_cause !== 3'd7) begin errors++; $display("[TB] FAIL sat_clr_first got %0d want 7", first_cause); end
    checks++; if (viol_cnt !== 8'hFF) begin errors++; $display("[TB] FAIL sat_clr_cnt got %h want ff", viol_cnt); end
  endtask

  task automatic test_clr_with_viol();
    pc = 16'h0000; clr_cause = 1'b1; viol = 6'b001100;
    tick();
    clr_cause = 1'b0; viol = '0;
    checks++; if (cause !== 6'h0C) begin errors++; $display("[TB] FAIL clrviol_cause got %h want 0c", cause); end
    checks++; if (first_cause !== 3'd2) begin errors++; $display("[TB] FAIL clrviol_first got %0d want 2", first_cause); end
    wait_idle();
  endtask

  task automatic test_reset_mid();
    int n;
    pc = 16'h1234; viol = 6'b000001;
    tick();
    viol = '0;
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (sys_rst !== 1'b0) begin errors++; $display("[TB] FAIL mid_sys_rst got %b want 0", sys_rst); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_busy got %b want 0", busy); end
    checks++; if (cause !== 6'h00) begin errors++; $display("[TB] FAIL mid_cause got %h want 00", cause); end
    checks++; if (first_cause !== 3'd7) begin errors++; $display("[TB] FAIL mid_first got %0d want 7", first_cause); end
    checks++; if (viol_cnt !== 8'h00) begin errors++; $display("[TB] FAIL mid_cnt got %h want 00", viol_cnt); end
    tick();
    reset_n = 1'b1;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_after_busy got %b want 0", busy); end
    checks++; if (sys_rst !== 1'b0) begin errors++; $display("[TB] FAIL mid_after_rst got %b want 0", sys_rst); end
    viol = 6'b000001;
    tick();
    viol = '0;
    checks++; if (viol_cnt !== 8'd1) begin errors++; $display("[TB] FAIL mid_new_cnt got %0d want 1", viol_cnt); end
    checks++; if (first_cause !== 3'd0) begin errors++; $display("[TB] FAIL mid_new_first got %0d want 0", first_cause); end
    measure_pulse(n);
    checks++; if (n !== 4) begin errors++; $display("[TB] FAIL mid_new_pulse got %0d want 4", n); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold_or();
    test_timeout();
    test_wait_priority();
    test_clr_in_hold();
    test_saturate();
    test_clr_with_viol();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
